// File: rtl/adxl362_burst_reader_if.sv
// SPI pins and published frame outputs of the ADXL362 burst reader.
// master = reader side, slave = sensor / consumer side.
interface adxl362_burst_reader_if #(
  parameter int NUM_AXES = 3
);
  logic                   enable;
  logic                   miso;
  logic                   sclk;
  logic                   mosi;
  logic                   cs;
  logic [16*NUM_AXES-1:0] axis_data;
  logic                   data_valid;
  logic                   init_done;
  logic                   busy;

  modport master (
    input  enable, miso,
    output sclk, mosi, cs, axis_data, data_valid, init_done, busy
  );

  modport slave (
    output enable, miso,
    input  sclk, mosi, cs, axis_data, data_valid, init_done, busy
  );
endinterface

// File: rtl/adxl362_burst_reader.sv
// ADXL362 reader: one POWER_CTL write after power-up, then periodic burst reads
// of NUM_AXES 16-bit axis registers, published atomically with a one-cycle strobe.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  S_PWRUP | wait PWRUP_TICKS after reset before touching the sensor
//  S_WR    | CS low, shift 0x0A 0x2D PWRCTL_VAL
//  S_GAP   | CS high, count GAP_TICKS; saturate until enable=1
//  S_RD    | CS low, shift 0x0B START_REG + 2*NUM_AXES dummy bytes
//  S_PUB   | copy shadow to axis_data, strobe data_valid
module adxl362_burst_reader #(
  parameter int         HALF_DIV    = 2,
  parameter int         NUM_AXES    = 3,
  parameter logic [7:0] START_REG   = 8'h0E,
  parameter logic [7:0] PWRCTL_VAL  = 8'h02,
  parameter int         PWRUP_TICKS = 24000,
  parameter int         GAP_TICKS   = 40000
) (
  input logic                    iclk,
  input logic                    rst,
  adxl362_burst_reader_if.master bus
);
  localparam int RXW     = 16 * NUM_AXES;
  localparam int TXW     = 16 + RXW;
  localparam int WR_BITS = 24;
  localparam int TMAX0   = (PWRUP_TICKS > GAP_TICKS) ? PWRUP_TICKS : GAP_TICKS;
  localparam int TMAX    = (TMAX0 > HALF_DIV) ? TMAX0 : HALF_DIV;
  localparam int TW      = $clog2(TMAX + 1);
  localparam int HW      = $clog2(2 * TXW + 2);

  localparam logic [TW-1:0] PWRUP_LAST = TW'(PWRUP_TICKS - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
  localparam logic [TW-1:0] HALF_LAST  = TW'(HALF_DIV - 1);
  localparam logic [HW-1:0] WR_HTOP    = HW'(2 * WR_BITS);
  localparam logic [HW-1:0] RD_HTOP    = HW'(2 * TXW);

  typedef enum logic [2:0] {S_PWRUP, S_WR, S_GAP, S_RD, S_PUB} state_t;

  state_t           state, state_n;
  logic [TW-1:0]    tmr, tmr_n;
  logic [HW-1:0]    hcnt, hcnt_n;
  logic             sclk_q, sclk_n;
  logic             cs_q, cs_n;
  logic [TXW-1:0]   tx_sr, tx_n;
  logic [RXW-1:0]   rx_sr, rx_n;
  logic [RXW-1:0]   axis_q, axis_n;
  logic [RXW-1:0]   shadow;
  logic             dv_q, dv_n;
  logic             init_q, init_n;
  logic             half_end;
  logic [HW-1:0]    h_top;

  // Byte k of the receive stream lands at shadow[8k+:8]: even k = L, odd k = H.
  always_comb begin
    shadow = '0;
    for (int k = 0; k < 2 * NUM_AXES; k++)
      shadow[8*k +: 8] = rx_sr[8*(2*NUM_AXES-1-k) +: 8];
  end

  always_ff @(posedge iclk or posedge rst) begin
    if (rst) begin
      state  <= S_PWRUP;
      tmr    <= '0;
      hcnt   <= '0;
      sclk_q <= 1'b0;
      cs_q   <= 1'b1;
      tx_sr  <= '0;
      rx_sr  <= '0;
      axis_q <= '0;
      dv_q   <= 1'b0;
      init_q <= 1'b0;
    end else begin
      state  <= state_n;
      tmr    <= tmr_n;
      hcnt   <= hcnt_n;
      sclk_q <= sclk_n;
      cs_q   <= cs_n;
      tx_sr  <= tx_n;
      rx_sr  <= rx_n;
      axis_q <= axis_n;
      dv_q   <= dv_n;
      init_q <= init_n;
    end
  end

  // Half-period index hcnt: 0 = CS setup, odd = SCLK high, even = SCLK low,
  // h_top+1 = CS hold before release.
  always_comb begin
    state_n  = state;
    tmr_n    = tmr;
    hcnt_n   = hcnt;
    sclk_n   = sclk_q;
    cs_n     = cs_q;
    tx_n     = tx_sr;
    rx_n     = rx_sr;
    axis_n   = axis_q;
    dv_n     = 1'b0;
    init_n   = init_q;
    half_end = (tmr == HALF_LAST);
    h_top    = (state == S_WR) ? WR_HTOP : RD_HTOP;
    case (state)
      S_PWRUP: begin
        if (tmr == PWRUP_LAST) begin
          state_n = S_WR;
          tmr_n   = '0;
          hcnt_n  = '0;
          cs_n    = 1'b0;
          sclk_n  = 1'b0;
          tx_n    = {8'h0A, 8'h2D, PWRCTL_VAL, {(TXW-WR_BITS){1'b0}}};
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      S_WR, S_RD: begin
        if (!half_end) begin
          tmr_n = tmr + TW'(1);
        end else begin
          tmr_n = '0;
          if (hcnt == h_top + HW'(1)) begin
            cs_n   = 1'b1;
            hcnt_n = '0;
            if (state == S_WR) begin
              init_n  = 1'b1;
              state_n = S_GAP;
            end else begin
              state_n = S_PUB;
            end
          end else begin
            hcnt_n = hcnt + HW'(1);
            if (!hcnt[0] && hcnt != h_top) begin
              sclk_n = 1'b1;
              if (state == S_RD)
                rx_n = {rx_sr[RXW-2:0], bus.miso};
            end else if (hcnt[0]) begin
              sclk_n = 1'b0;
              tx_n   = {tx_sr[TXW-2:0], 1'b0};
            end
          end
        end
      end
      S_GAP: begin
        if (tmr >= GAP_LAST) begin
          if (bus.enable) begin
            state_n = S_RD;
            tmr_n   = '0;
            hcnt_n  = '0;
            cs_n    = 1'b0;
            sclk_n  = 1'b0;
            tx_n    = {8'h0B, START_REG, {RXW{1'b0}}};
          end
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      S_PUB: begin
        // Timer already runs here so the gap is measured from the CS rise.
        axis_n  = shadow;
        dv_n    = 1'b1;
        tmr_n   = tmr + TW'(1);
        state_n = S_GAP;
      end
      default: state_n = S_PWRUP;
    endcase
  end

  assign bus.sclk       = sclk_q;
  assign bus.mosi       = tx_sr[TXW-1];
  assign bus.cs         = cs_q;
  assign bus.axis_data  = axis_q;
  assign bus.data_valid = dv_q;
  assign bus.init_done  = init_q;
  assign bus.busy       = ~cs_q;
endmodule

// File: tb/tb_adxl362_burst_reader.sv
// Bench for adxl362_burst_reader: two instances (3 axes / HALF_DIV 2, 1 axis / HALF_DIV 1)
// driven by a byte-level ADXL362 sensor model with random register contents.
module tb_adxl362_burst_reader;
  localparam int PWRUP = 20;
  localparam int GAP   = 50;

  logic iclk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  always #5 iclk = ~iclk;

  adxl362_burst_reader_if #(.NUM_AXES(3)) bus0 ();
  adxl362_burst_reader_if #(.NUM_AXES(1)) bus1 ();

  adxl362_burst_reader #(
    .HALF_DIV(2), .NUM_AXES(3), .START_REG(8'h0E), .PWRCTL_VAL(8'h02),
    .PWRUP_TICKS(PWRUP), .GAP_TICKS(GAP)
  ) dut0 (.iclk(iclk), .rst(rst0), .bus(bus0));

  adxl362_burst_reader #(
    .HALF_DIV(1), .NUM_AXES(1), .START_REG(8'h0E), .PWRCTL_VAL(8'h02),
    .PWRUP_TICKS(PWRUP), .GAP_TICKS(GAP)
  ) dut1 (.iclk(iclk), .rst(rst1), .bus(bus1));

  logic sclk_w [2], mosi_w [2], cs_w [2], dv_w [2], init_w [2], busy_w [2];
  logic miso_r [2];
  logic en_r   [2];
  logic [63:0] ax0, ax1;

  assign sclk_w[0] = bus0.sclk;        assign sclk_w[1] = bus1.sclk;
  assign mosi_w[0] = bus0.mosi;        assign mosi_w[1] = bus1.mosi;
  assign cs_w[0]   = bus0.cs;          assign cs_w[1]   = bus1.cs;
  assign dv_w[0]   = bus0.data_valid;  assign dv_w[1]   = bus1.data_valid;
  assign init_w[0] = bus0.init_done;   assign init_w[1] = bus1.init_done;
  assign busy_w[0] = bus0.busy;        assign busy_w[1] = bus1.busy;
  assign bus0.miso   = miso_r[0];      assign bus1.miso   = miso_r[1];
  assign bus0.enable = en_r[0];        assign bus1.enable = en_r[1];
  assign ax0 = {16'h0, bus0.axis_data};
  assign ax1 = {48'h0, bus1.axis_data};

  int nax [2] = '{3, 1};
  int hd  [2] = '{2, 1};

  logic [7:0] resp [2][8];
  logic [7:0] mb   [2][16];
  logic [7:0] lf_b [2][16];
  logic [7:0] sh   [2];
  int mcnt [2], rises [2], falls [2], lf_cnt [2], lf_rises [2];
  int dv_cnt [2], fall_cnt [2], fall_cyc [2], rise_cyc [2], last_gap [2], last_low [2];
  logic s_prev [2] = '{1'b0, 1'b0};
  logic c_prev [2] = '{1'b1, 1'b1};
  logic m_prev [2] = '{1'b0, 1'b0};
  int viol_idle = 0, viol_mosi = 0;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;

  function automatic logic stream_bit(int i, int idx);
    int b = idx / 8;
    if (b >= 2 && b < 2 + 2 * nax[i]) return resp[i][b-2][7 - (idx % 8)];
    return 1'b0;
  endfunction

  function automatic logic [63:0] exp_axis(int i);
    logic [63:0] e = '0;
    for (int n = 0; n < nax[i]; n++) e[16*n +: 16] = {resp[i][2*n+1], resp[i][2*n]};
    return e;
  endfunction

  initial forever begin
    @(posedge iclk);
    cyc++;
  end

  // Sensor model: decodes MOSI on SCLK rises, shifts MISO out on SCLK falls.
  initial begin
    miso_r[0] = 1'b0;
    miso_r[1] = 1'b0;
    forever begin
      @(negedge iclk);
      for (int i = 0; i < 2; i++) begin
        if (cs_w[i] === 1'b1 && sclk_w[i] === 1'b1) viol_idle++;
        if (!cs_w[i] && !c_prev[i] && mosi_w[i] != m_prev[i] && !(s_prev[i] && !sclk_w[i]))
          viol_mosi++;
        if (c_prev[i] && cs_w[i] === 1'b0) begin
          fall_cnt[i]++;
          last_gap[i] = cyc - rise_cyc[i];
          fall_cyc[i] = cyc;
          mcnt[i] = 0; rises[i] = 0; falls[i] = 0; sh[i] = 8'h00;
          miso_r[i] = stream_bit(i, 0);
        end else if (cs_w[i] === 1'b0) begin
          if (!s_prev[i] && sclk_w[i]) begin
            sh[i] = {sh[i][6:0], mosi_w[i]};
            rises[i]++;
            if (rises[i] % 8 == 0 && mcnt[i] < 16) begin
              mb[i][mcnt[i]] = sh[i];
              mcnt[i]++;
            end
          end else if (s_prev[i] && !sclk_w[i]) begin
            falls[i]++;
            miso_r[i] = stream_bit(i, falls[i]);
          end
        end
        if (!c_prev[i] && cs_w[i] === 1'b1) begin
          last_low[i] = cyc - fall_cyc[i];
          rise_cyc[i] = cyc;
          lf_cnt[i]   = mcnt[i];
          lf_rises[i] = rises[i];
          for (int k = 0; k < 16; k++) lf_b[i][k] = mb[i][k];
        end
        if (dv_w[i] === 1'b1) dv_cnt[i]++;
        s_prev[i] = sclk_w[i];
        c_prev[i] = (cs_w[i] !== 1'b0);
        m_prev[i] = mosi_w[i];
      end
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic settle();
    @(negedge iclk);
    #1;
  endtask

  task automatic wait_cs(input int i, input logic lvl, input int budget, input string tag,
                         output int n);
    n = 0;
    while (cs_w[i] !== lvl && n < budget) begin
      @(posedge iclk); #1; n++;
    end
    if (cs_w[i] !== lvl) check_val({tag, " timeout"}, 0, 1);
  endtask

  task automatic wait_dv(input int i, input int budget, input string tag);
    int n = 0;
    while (dv_w[i] !== 1'b1 && n < budget) begin
      @(posedge iclk); #1; n++;
    end
    if (dv_w[i] !== 1'b1) check_val({tag, " timeout"}, 0, 1);
  endtask

  task automatic wait_rises(input int i, input int target, input int budget, input string tag);
    int n = 0;
    while (rises[i] < target && n < budget) begin
      @(posedge iclk); #1; n++;
    end
    if (rises[i] < target) check_val({tag, " timeout"}, 0, 1);
  endtask

  task automatic check_wr_frame(input int i, input string tag);
    logic [7:0] wr_exp [3] = '{8'h0A, 8'h2D, 8'h02};
    check_val({tag, " rises"}, lf_rises[i], 24);
    check_val({tag, " nbytes"}, lf_cnt[i], 3);
    for (int k = 0; k < 3; k++) check_val({tag, " mosi"}, lf_b[i][k], wr_exp[k]);
  endtask

  task automatic check_rd_frame(input int i, input string tag);
    int nb = 2 + 2 * nax[i];
    int lo = 8 * nb * 2 * hd[i] + 2 * hd[i];
    check_val({tag, " rises"}, lf_rises[i], 8 * nb);
    check_val({tag, " nbytes"}, lf_cnt[i], nb);
    for (int k = 0; k < nb; k++)
      check_val({tag, " mosi"}, lf_b[i][k], (k == 0) ? 8'h0B : (k == 1) ? 8'h0E : 8'h00);
    check_val({tag, " cs_low_len"}, (last_low[i] >= lo && last_low[i] <= lo + 2 * hd[i]), 1);
  endtask

  task automatic rand_resp(input int i);
    for (int k = 0; k < 8; k++) resp[i][k] = 8'($urandom_range(255));
  endtask

  initial begin
    int n, exp_dv, prev_fall, prev_low, falls_hold;
    logic [63:0] hold;
    logic [7:0] first [6] = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    exp_dv = 0; prev_fall = 0; prev_low = 0;
    for (int k = 0; k < 8; k++) begin
      resp[0][k] = (k < 6) ? first[k] : 8'h00;
      resp[1][k] = (k < 2) ? first[k] : 8'h00;
    end
    en_r[0] = 1'b1;
    en_r[1] = 1'b1;
    #1 rst0 = 1'b1; rst1 = 1'b1;
    repeat (3) @(posedge iclk);
    #1;
    check_val("rst cs", cs_w[0], 1);
    check_val("rst sclk", sclk_w[0], 0);
    check_val("rst mosi", mosi_w[0], 0);
    check_val("rst axis", ax0, 0);
    check_val("rst dv", dv_w[0], 0);
    check_val("rst init", init_w[0], 0);
    check_val("rst busy", busy_w[0], 0);
    rst0 = 1'b0;

    // power-up delay and POWER_CTL write
    wait_cs(0, 1'b0, 100, "pwrup", n);
    check_val("pwrup latency", (n >= 19 && n <= 21), 1);
    check_val("init during write", init_w[0], 0);
    check_val("busy during write", busy_w[0], 1);
    wait_cs(0, 1'b1, 500, "wr end", n);
    check_val("init after write", init_w[0], 1);
    settle();
    check_wr_frame(0, "wr");

    // back-to-back read frames
    for (int f = 0; f < 4; f++) begin
      if (f > 0) rand_resp(0);
      wait_cs(0, 1'b0, 400, "rd start", n);
      settle();
      check_val("gap len", last_gap[0], GAP);
      if (f > 0) check_val("fall spacing", fall_cyc[0] - prev_fall, prev_low + GAP);
      prev_fall = fall_cyc[0];
      wait_dv(0, 1000, "rd dv");
      check_val("axis data", ax0, exp_axis(0));
      if (f == 0) begin
        check_val("axis first", ax0, 64'h9ABC_5678_1234);
        @(posedge iclk); #1;
        check_val("dv width", dv_w[0], 0);
      end
      settle();
      check_rd_frame(0, "rd");
      prev_low = last_low[0];
      exp_dv++;
      check_val("dv count", dv_cnt[0], exp_dv);
    end

    // enable dropped during byte 3: frame still publishes, then no more frames
    rand_resp(0);
    wait_cs(0, 1'b0, 400, "en start", n);
    wait_rises(0, 26, 400, "en byte3");
    en_r[0] = 1'b0;
    wait_dv(0, 1000, "en dv");
    check_val("en axis", ax0, exp_axis(0));
    hold = ax0;
    falls_hold = fall_cnt[0];
    repeat (200) @(posedge iclk);
    #1;
    check_val("en idle falls", fall_cnt[0], falls_hold);
    check_val("en idle cs", cs_w[0], 1);
    check_val("en axis hold", ax0, hold);
    exp_dv++;
    check_val("en dv count", dv_cnt[0], exp_dv);
    rand_resp(0);
    en_r[0] = 1'b1;
    wait_cs(0, 1'b0, 10, "reenable", n);
    check_val("reenable latency", (n <= 1), 1);

    // reset during byte 4 of that frame
    wait_rises(0, 36, 400, "rst byte4");
    @(negedge iclk); #2;
    rst0 = 1'b1;
    #1;
    check_val("midrst cs", cs_w[0], 1);
    check_val("midrst sclk", sclk_w[0], 0);
    check_val("midrst axis", ax0, 0);
    check_val("midrst dv", dv_w[0], 0);
    check_val("midrst init", init_w[0], 0);
    repeat (3) @(posedge iclk);
    #1 rst0 = 1'b0;
    wait_cs(0, 1'b0, 100, "re-pwrup", n);
    check_val("re-pwrup latency", (n >= 19 && n <= 21), 1);
    wait_cs(0, 1'b1, 500, "re-wr end", n);
    settle();
    check_wr_frame(0, "re-wr");
    check_val("no dv after rst", dv_cnt[0], exp_dv);
    wait_dv(0, 1000, "post-rst dv");
    check_val("post-rst axis", ax0, exp_axis(0));

    // single axis, HALF_DIV=1
    @(posedge iclk); #1 rst1 = 1'b0;
    wait_cs(1, 1'b0, 100, "d1 pwrup", n);
    check_val("d1 pwrup latency", (n >= 19 && n <= 21), 1);
    wait_cs(1, 1'b1, 500, "d1 wr end", n);
    settle();
    check_wr_frame(1, "d1 wr");
    wait_dv(1, 1000, "d1 dv");
    check_val("d1 axis first", ax1, 64'h1234);
    settle();
    check_rd_frame(1, "d1 rd");
    for (int f = 0; f < 3; f++) begin
      rand_resp(1);
      wait_cs(1, 1'b0, 400, "d1 start", n);
      wait_dv(1, 1000, "d1 dv");
      check_val("d1 axis", ax1, exp_axis(1));
    end

    check_val("sclk low while cs high", viol_idle, 0);
    check_val("mosi changes only on sclk fall", viol_mosi, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
